// File: rtl/uart_tx_if.sv
// Write port from the data memory into the UART transmitter.
// uart_we is a one-cycle push strobe with no ready: the master checks full first, a push while full is dropped.
interface uart_tx_if;
    logic [31:0] uart_dout;
    logic        uart_we;

    modport master (output uart_dout, output uart_we);
    modport slave  (input  uart_dout, input  uart_we);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by a circular byte FIFO; txd is driven straight from a flop.
// state_dbg exposes the framing FSM state (0=IDLE, 1=START, 2=DATA, 3=STOP).
module uart_tx #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       txd,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]              BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic push;
    logic pop;
    logic empty;
    logic baud_done;
    logic [7:0] head;
    logic unused_upper;

    assign unused_upper = ^bus.uart_dout[31:8];

    assign empty     = (count == '0);
    assign full      = (count == COUNT_FULL);
    assign busy      = (state != IDLE) || !empty;
    assign state_dbg = state;
    assign baud_done = (baud == BAUD_LAST);
    assign head      = mem[rd_ptr];

    // full is taken from the pre-edge count, so a same-cycle pop never rescues a write into a full FIFO.
    assign push = bus.uart_we && !full;
    assign pop  = !empty && ((state == IDLE) || (state == STOP && baud_done));

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.uart_dout[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.uart_we && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            txd     <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift <= head;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        txd     <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            // Next bit is shift[1] because the register shifts on this same edge.
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4 and a 16-entry FIFO.
// Frames are checked bit-exactly on every falling edge; t=0 is the first falling edge of a start bit.
module tb_uart_tx;
    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       txd;
    logic       full;
    logic       busy;
    logic       overflow;
    logic [1:0] state_dbg;

    int checks;
    int failures;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .txd       (txd),
        .full      (full),
        .busy      (busy),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic got, input logic exp, input string tag);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.uart_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Checks txd (and busy) at frame offsets k0..k1-1, leaving the bench at offset k1.
    task automatic recv_bits(input logic [7:0] b, input int k0, input int k1, input string tag);
        logic exp;
        for (int k = k0; k < k1; k++) begin
            if (k < 4)       exp = 1'b0;
            else if (k < 36) exp = b[(k - 4) / CPB];
            else             exp = 1'b1;
            check(txd, exp, $sformatf("%s_t%0d", tag, k));
            check(busy, 1'b1, $sformatf("%s_busy_t%0d", tag, k));
            @(negedge clk);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check(txd, 1'b1, $sformatf("%s_txd_%0d", tag, i));
            check(busy, 1'b0, $sformatf("%s_busy_%0d", tag, i));
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.uart_we = 1'b0;
        bus.uart_dout = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check(txd, 1'b1, "rst_txd");
        check(full, 1'b0, "rst_full");
        check(busy, 1'b0, "rst_busy");
        check(overflow, 1'b0, "rst_overflow");

        // Single write 0x55: txd still high after edge N, low after edge N+1
        bus.uart_dout = 32'h0000_0055;
        bus.uart_we = 1'b1;
        @(negedge clk);
        bus.uart_we = 1'b0;
        check(txd, 1'b1, "lat_txd_n");
        check(busy, 1'b1, "lat_busy_n");
        @(negedge clk);
        recv_bits(8'h55, 0, 40, "f55");
        idle_check(3, "after55");

        // Upper bits ignored
        bus.uart_dout = 32'hDEAD_BEA5;
        bus.uart_we = 1'b1;
        @(negedge clk);
        bus.uart_we = 1'b0;
        @(negedge clk);
        recv_bits(8'hA5, 0, 40, "fA5");
        idle_check(3, "afterA5");

        // Back-to-back frames from consecutive writes
        bus.uart_dout = 32'h41;
        bus.uart_we = 1'b1;
        @(negedge clk);
        bus.uart_dout = 32'h42;
        @(negedge clk);
        bus.uart_we = 1'b0;
        check(full, 1'b0, "b2b_full");
        recv_bits(8'h41, 0, 40, "f41");
        recv_bits(8'h42, 0, 40, "f42");
        idle_check(3, "after42");

        // 18 consecutive writes: 1 in flight, 16 queued, 18th dropped
        for (int i = 1; i <= 18; i++) begin
            bus.uart_dout = 32'(8'h10 + i);
            bus.uart_we = 1'b1;
            @(negedge clk);
        end
        bus.uart_we = 1'b0;
        check(full, 1'b1, "ovf_full");
        check(overflow, 1'b1, "ovf_flag");
        recv_bits(8'h11, 16, 40, "ovf_f1");
        check(full, 1'b0, "ovf_full_after_pop");
        for (int i = 2; i <= 17; i++) begin
            recv_bits(8'(8'h10 + i), 0, 40, $sformatf("ovf_f%0d", i));
        end
        idle_check(3, "ovf_drained");
        check(overflow, 1'b1, "ovf_sticky");
        check(full, 1'b0, "ovf_drained_full");

        // Reset mid-DATA with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            bus.uart_dout = 32'(8'hC0 + i);
            bus.uart_we = 1'b1;
            @(negedge clk);
        end
        bus.uart_we = 1'b0;
        recv_bits(8'hC0, 2, 20, "abort_f");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(txd, 1'b1, "abort_txd");
        check(busy, 1'b0, "abort_busy");
        check(full, 1'b0, "abort_full");
        check(overflow, 1'b0, "abort_overflow");
        idle_check(60, "abort_quiet");

        // Write while full on the same edge as the STOP->START pop
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            bus.uart_dout = 32'(8'h60 + i);
            bus.uart_we = 1'b1;
            @(negedge clk);
        end
        bus.uart_we = 1'b0;
        check(full, 1'b1, "race_full");
        check(overflow, 1'b0, "race_no_ovf_yet");
        recv_bits(8'h61, 15, 39, "race_f1");
        bus.uart_dout = 32'hEE;
        bus.uart_we = 1'b1;
        @(negedge clk);
        bus.uart_we = 1'b0;
        check(overflow, 1'b1, "race_overflow");
        check(full, 1'b0, "race_count15");
        for (int i = 2; i <= 17; i++) begin
            recv_bits(8'(8'h60 + i), 0, 40, $sformatf("race_f%0d", i));
        end
        idle_check(50, "race_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
